burst_memory_driver: RTL and testbench

BURST_MEMORY_DRIVER -- requirements
Module: burst_memory_driver

---
 rtl/burst_memory_driver_pkg.sv | 21 ++
 rtl/burst_memory_driver_if.sv | 45 ++++
 rtl/burst_beat_counter.sv | 35 +++
 rtl/burst_memory_driver.sv | 150 +++++++++++++++
 tb/tb_burst_memory_driver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_memory_driver_pkg.sv
// Shared types and default sizing for the burst memory driver.
package burst_memory_driver_pkg;

    localparam int DEF_ADDR_W    = 26;
    localparam int DEF_DATA_W    = 128;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_CMD   = 2'd2,
        ST_RD_DATA  = 2'd3
    } state_e;

    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    localparam int DEF_BURST_W = burst_w(DEF_MAX_BURST);

endpackage

// File: rtl/burst_memory_driver_if.sv
// User command/data side plus Avalon burst master side of the driver.
interface burst_memory_driver_if
    import burst_memory_driver_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BURST_W = DEF_BURST_W
) ();

    logic [ADDR_W-1:0]  address;
    logic [BURST_W-1:0] burst_len;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  wdata;
    logic               wdata_take;
    logic [DATA_W-1:0]  rdata;
    logic               rdata_valid;
    logic               pending;
    logic               done;

    logic [ADDR_W-1:0]  avl_address;
    logic [BURST_W-1:0] avl_count;
    logic               avl_begin;
    logic               avl_read;
    logic               avl_write;
    logic [DATA_W-1:0]  avl_wdata;
    logic [DATA_W-1:0]  avl_rdata;
    logic               avl_wait;
    logic               avl_rdata_valid;

    modport master (
        input  address, burst_len, read, write, wdata,
        input  avl_rdata, avl_wait, avl_rdata_valid,
        output wdata_take, rdata, rdata_valid, pending, done,
        output avl_address, avl_count, avl_begin, avl_read, avl_write, avl_wdata
    );

    modport slave (
        output address, burst_len, read, write, wdata,
        output avl_rdata, avl_wait, avl_rdata_valid,
        input  wdata_take, rdata, rdata_valid, pending, done,
        input  avl_address, avl_count, avl_begin, avl_read, avl_write, avl_wdata
    );

endinterface

// File: rtl/burst_beat_counter.sv
// Beats-remaining counter shared by the read and write paths; flags the final beat.
module burst_beat_counter #(
    parameter int BURST_W = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [BURST_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               last_o
);

    logic [BURST_W-1:0] count_q;
    logic [BURST_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - BURST_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == BURST_W'(1));

endmodule

// File: rtl/burst_memory_driver.sv
// Avalon burst master: turns single read/write burst commands into Avalon bursts.
//   state       | meaning
//   ST_IDLE     | waiting for a command with non-zero length
//   ST_WR_BURST | presenting write beats, one per non-waited cycle
//   ST_RD_CMD   | read command held until the slave drops avl_wait
//   ST_RD_DATA  | collecting returned read beats
module burst_memory_driver
    import burst_memory_driver_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    burst_memory_driver_if.master bus
);

    localparam int BURST_W = burst_w(MAX_BURST);

    state_e             state_q;
    logic [ADDR_W-1:0]  avl_address_q;
    logic [BURST_W-1:0] avl_count_q;
    logic               avl_begin_q;
    logic               avl_read_q;
    logic               avl_write_q;
    logic [DATA_W-1:0]  avl_wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rdata_valid_q;
    logic               pending_q;
    logic               done_q;

    logic [BURST_W-1:0] len_eff;
    logic               len_legal;
    logic               rd_accept;
    logic               wr_accept;
    logic               wr_beat_ok;
    logic               rd_beat;
    logic               beat_last;

    // Over-length requests are clamped rather than rejected.
    always_comb begin
        len_eff = bus.burst_len;
        if (bus.burst_len > BURST_W'(MAX_BURST)) begin
            len_eff = BURST_W'(MAX_BURST);
        end
    end

    assign len_legal  = (bus.burst_len != '0);
    assign rd_accept  = (state_q == ST_IDLE) && bus.read && len_legal;
    assign wr_accept  = (state_q == ST_IDLE) && !bus.read && bus.write && len_legal;
    assign wr_beat_ok = (state_q == ST_WR_BURST) && !bus.avl_wait;
    assign rd_beat    = ((state_q == ST_RD_CMD) || (state_q == ST_RD_DATA)) && bus.avl_rdata_valid;

    burst_beat_counter #(
        .BURST_W (BURST_W)
    ) u_beat_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (rd_accept || wr_accept),
        .load_val_i (len_eff),
        .dec_i      (wr_beat_ok || rd_beat),
        .last_o     (beat_last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            avl_address_q <= '0;
            avl_count_q   <= '0;
            avl_begin_q   <= 1'b0;
            avl_read_q    <= 1'b0;
            avl_write_q   <= 1'b0;
            avl_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            pending_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_accept) begin
                        avl_address_q <= bus.address;
                        avl_count_q   <= len_eff;
                        avl_begin_q   <= 1'b1;
                        avl_read_q    <= 1'b1;
                        pending_q     <= 1'b1;
                        state_q       <= ST_RD_CMD;
                    end else if (wr_accept) begin
                        avl_address_q <= bus.address;
                        avl_count_q   <= len_eff;
                        avl_begin_q   <= 1'b1;
                        avl_write_q   <= 1'b1;
                        avl_wdata_q   <= bus.wdata;
                        pending_q     <= 1'b1;
                        state_q       <= ST_WR_BURST;
                    end
                end
                ST_WR_BURST: begin
                    if (!bus.avl_wait) begin
                        avl_begin_q <= 1'b0;
                        if (beat_last) begin
                            avl_write_q <= 1'b0;
                            done_q      <= 1'b1;
                            pending_q   <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            avl_wdata_q <= bus.wdata;
                        end
                    end
                end
                ST_RD_CMD, ST_RD_DATA: begin
                    if ((state_q == ST_RD_CMD) && !bus.avl_wait) begin
                        avl_read_q  <= 1'b0;
                        avl_begin_q <= 1'b0;
                        state_q     <= ST_RD_DATA;
                    end
                    // A final beat overrides the command-phase transition above.
                    if (bus.avl_rdata_valid) begin
                        rdata_q       <= bus.avl_rdata;
                        rdata_valid_q <= 1'b1;
                        if (beat_last) begin
                            avl_read_q  <= 1'b0;
                            avl_begin_q <= 1'b0;
                            done_q      <= 1'b1;
                            pending_q   <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wdata_take  = !reset_i && (wr_accept || (wr_beat_ok && !beat_last));
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.pending     = pending_q;
    assign bus.done        = done_q;
    assign bus.avl_address = avl_address_q;
    assign bus.avl_count   = avl_count_q;
    assign bus.avl_begin   = avl_begin_q;
    assign bus.avl_read    = avl_read_q;
    assign bus.avl_write   = avl_write_q;
    assign bus.avl_wdata   = avl_wdata_q;

endmodule

// File: tb/tb_burst_memory_driver.sv
// Randomized bench for burst_memory_driver against a transaction-level model of each burst.
module tb_burst_memory_driver;
    import burst_memory_driver_pkg::*;

    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 16;
    localparam int BURST_W   = $clog2(MAX_BURST) + 1;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    burst_memory_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

    burst_memory_driver #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int eff_len(input int len);
        return (len > MAX_BURST) ? MAX_BURST : len;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"},   bus.rdata, 128'(0));
        check({tag, "_rvalid"},  128'(bus.rdata_valid), 128'(0));
        check({tag, "_pending"}, 128'(bus.pending), 128'(0));
        check({tag, "_done"},    128'(bus.done), 128'(0));
        check({tag, "_addr"},    128'(bus.avl_address), 128'(0));
        check({tag, "_count"},   128'(bus.avl_count), 128'(0));
        check({tag, "_begin"},   128'(bus.avl_begin), 128'(0));
        check({tag, "_read"},    128'(bus.avl_read), 128'(0));
        check({tag, "_write"},   128'(bus.avl_write), 128'(0));
        check({tag, "_wdata"},   bus.avl_wdata, 128'(0));
    endtask

    // Entered and left just after a falling edge; leaves the DUT in IDLE.
    task automatic run_write(input logic [ADDR_W-1:0] addr, input int len, input int wait_pct,
                             input int wait_beat, input int wait_cycles, input int abort_at);
        logic [127:0] data [MAX_BURST+1];
        int  eff = eff_len(len);
        int  ptr = 1, acc = 0, wcnt = 0, cyc = 0, takes = 1;
        bit  w, exp_take;
        for (int i = 0; i <= MAX_BURST; i++) data[i] = rnd128();
        bus.address   = addr;
        bus.burst_len = BURST_W'(len);
        bus.read      = 1'b0;
        bus.write     = 1'b1;
        bus.wdata     = data[0];
        bus.avl_wait  = 1'b0;
        #1 check("wr_take_accept", 128'(bus.wdata_take), 128'(1));
        @(posedge clk);
        while (acc < eff && cyc < eff * 20 + 20) begin
            @(negedge clk);
            cyc++;
            bus.write = 1'($urandom_range(0, 1));
            bus.read  = 1'($urandom_range(0, 1));
            check("wr_pending", 128'(bus.pending), 128'(1));
            check("wr_avl_write", 128'(bus.avl_write), 128'(1));
            check("wr_avl_read", 128'(bus.avl_read), 128'(0));
            check("wr_addr", 128'(bus.avl_address), 128'(addr));
            check("wr_count", 128'(bus.avl_count), 128'(eff));
            check("wr_begin", 128'(bus.avl_begin), 128'(acc == 0));
            check("wr_wdata", bus.avl_wdata, data[acc]);
            check("wr_done_early", 128'(bus.done), 128'(0));
            if (abort_at > 0 && acc == abort_at) begin
                reset     = 1'b1;
                bus.write = 1'b0;
                bus.read  = 1'b0;
                #1 check("rst_take", 128'(bus.wdata_take), 128'(0));
                @(posedge clk);
                @(negedge clk);
                check_all_zero("rst_abort");
                reset = 1'b0;
                return;
            end
            w = (acc == wait_beat && wcnt < wait_cycles) ? 1'b1 : ($urandom_range(0, 99) < wait_pct);
            bus.avl_wait = w;
            bus.wdata    = data[ptr];
            exp_take     = !w && (acc + 1 < eff);
            #1 check("wr_take", 128'(bus.wdata_take), 128'(exp_take));
            if (bus.wdata_take) takes++;
            @(posedge clk);
            if (w) begin
                wcnt++;
            end else begin
                acc++;
                wcnt = 0;
            end
            if (exp_take) ptr++;
        end
        if (acc < eff) check("wr_timeout", 128'(acc), 128'(eff));
        @(negedge clk);
        bus.avl_wait = 1'b0;
        bus.write    = 1'b0;
        bus.read     = 1'b0;
        check("wr_done", 128'(bus.done), 128'(1));
        check("wr_pending_end", 128'(bus.pending), 128'(0));
        check("wr_write_end", 128'(bus.avl_write), 128'(0));
        check("wr_take_count", 128'(takes), 128'(eff));
    endtask

    task automatic run_read(input logic [ADDR_W-1:0] addr, input int len, input bit both,
                            input int wait_cycles, input int valid_pct);
        int  eff = eff_len(len);
        int  sent = 0, got = 0, cwait = 0, cyc = 0;
        bit  cmd_done = 0, finished = 0, exp_rv = 0, exp_done = 0, v, w;
        logic [127:0] exp_rd = '0, d;
        bus.address   = addr;
        bus.burst_len = BURST_W'(len);
        bus.read      = 1'b1;
        bus.write     = both;
        bus.avl_wait  = 1'b0;
        #1 check("rd_take_accept", 128'(bus.wdata_take), 128'(0));
        @(posedge clk);
        while (!finished && cyc < eff * 40 + 40) begin
            @(negedge clk);
            cyc++;
            bus.read  = 1'($urandom_range(0, 1));
            bus.write = 1'($urandom_range(0, 1));
            check("rd_rvalid", 128'(bus.rdata_valid), 128'(exp_rv));
            if (exp_rv) begin
                check("rd_rdata", bus.rdata, exp_rd);
                got++;
            end
            check("rd_done", 128'(bus.done), 128'(exp_done));
            check("rd_pending", 128'(bus.pending), 128'(!exp_done));
            check("rd_avl_write", 128'(bus.avl_write), 128'(0));
            if (exp_done) begin
                finished = 1;
            end else begin
                check("rd_avl_read", 128'(bus.avl_read), 128'(!cmd_done));
                check("rd_begin", 128'(bus.avl_begin), 128'(!cmd_done));
                check("rd_addr", 128'(bus.avl_address), 128'(addr));
                check("rd_count", 128'(bus.avl_count), 128'(eff));
                v = 0;
                w = 0;
                if (!cmd_done) begin
                    w = (cwait < wait_cycles) ? 1'b1 : ($urandom_range(0, 3) == 0);
                    cwait++;
                end else begin
                    v = (sent < eff) && ($urandom_range(0, 99) < valid_pct);
                end
                d = rnd128();
                bus.avl_wait        = w;
                bus.avl_rdata_valid = v;
                bus.avl_rdata       = d;
                exp_rv   = v;
                exp_rd   = d;
                exp_done = v && (sent + 1 == eff);
                if (v) sent++;
                if (!cmd_done && !w) cmd_done = 1;
                @(posedge clk);
            end
        end
        if (!finished) check("rd_timeout", 128'(sent), 128'(eff));
        bus.avl_rdata_valid = 1'b0;
        bus.avl_wait        = 1'b0;
        bus.read            = 1'b0;
        bus.write           = 1'b0;
        check("rd_beats", 128'(got), 128'(eff));
    endtask

    task automatic run_ignore(input int ncycles);
        bus.burst_len = '0;
        for (int i = 0; i < ncycles; i++) begin
            bus.read  = 1'b1;
            bus.write = 1'b1;
            #1 check("ign_take", 128'(bus.wdata_take), 128'(0));
            @(posedge clk);
            @(negedge clk);
            check("ign_pending", 128'(bus.pending), 128'(0));
            check("ign_begin", 128'(bus.avl_begin), 128'(0));
            check("ign_read", 128'(bus.avl_read), 128'(0));
            check("ign_write", 128'(bus.avl_write), 128'(0));
            check("ign_done", 128'(bus.done), 128'(0));
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_pending", 128'(bus.pending), 128'(0));
            check("idle_done", 128'(bus.done), 128'(0));
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus.address         = '0;
        bus.burst_len       = '0;
        bus.read            = 1'b0;
        bus.write           = 1'b0;
        bus.wdata           = '0;
        bus.avl_rdata       = '0;
        bus.avl_wait        = 1'b0;
        bus.avl_rdata_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        bus.write     = 1'b1;
        bus.burst_len = BURST_W'(4);
        #1 check("reset_take", 128'(bus.wdata_take), 128'(0));
        bus.write = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        @(negedge clk);

        run_write(ADDR_W'('h100), 4, 0, -1, 0, 0);
        run_write(ADDR_W'($urandom), 2, 0, 1, 3, 0);
        run_read(ADDR_W'($urandom), 3, 1'b0, 2, 50);
        run_ignore(2);
        // 31 is the largest over-length value the 5-bit length field can carry.
        run_read(ADDR_W'($urandom), 31, 1'b1, 0, 70);
        idle(1);

        run_write(ADDR_W'($urandom), 8, 20, -1, 0, 2);
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = rnd128();
        @(posedge clk);
        @(negedge clk);
        bus.avl_rdata_valid = 1'b0;
        check("late_rvalid", 128'(bus.rdata_valid), 128'(0));
        check("late_pending", 128'(bus.pending), 128'(0));
        run_read(ADDR_W'($urandom), 5, 1'b0, 1, 60);

        for (int i = 0; i < 40; i++) begin
            int len;
            int gap;
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            if (len == 0) begin
                run_ignore(1);
            end else if ($urandom_range(0, 1) == 0) begin
                run_write(ADDR_W'($urandom), len, int'($urandom_range(0, 50)), -1, 0, 0);
            end else begin
                run_read(ADDR_W'($urandom), len, 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), int'($urandom_range(30, 100)));
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
